int_ctrl: RTL and testbench
===========================

# int_ctrl

Interrupt controller between the edge-detecting input ports and the PicoBlaze core. It latches rising edges from up to 8 interrupt sources into a pending register and gates them with a mask register. It drives the core's `interrupt` line and retires it on `interrupt_ack`. Firmware accesses mask, pending and a priority-encoded source ID through the normal port bus (address/value/wen), and the read data goes to the input port selector.

## Interface
- `NSRC`, 4: number of interrupt sources, 1..8.
- `ADDR_MASK`, 8'h00: mask register address (read/write); must be set at instantiation.
- `ADDR_PEND`, 8'h01: pending register address (read; write-1-to-clear); must be set at instantiation.
- `ADDR_ID`, 8'h02: source ID address (read only); must be set at instantiation.

Ports (reset rst, synchronous, active-high; clock clk):
- `clk` in 1: system clock.
- `rst` in 1: synchronous reset, active-high.
- `address` in 8: CPU port_id.
- `value_in` in 8: CPU out_port data.
- `wen` in 1: CPU write_strobe.
- `ren` in 1: CPU read_strobe.
- `irq_in` in NSRC: source lines, e.g. inport_ioc int_out; synchronous to clk.
- `port_out` out 8: registered read data, to in_port_selector.
- `interrupt` out 1: to CPU interrupt input.
- `interrupt_ack` in 1: from CPU interrupt_ack.

## Operation
- `prev[NSRC-1:0]` is updated every cycle: `prev <= irq_in`. An edge is `irq_in & ~prev`. `prev` resets to 0, so a source already high when reset is released produces an edge on the first cycle.
- `pending` is updated every cycle as `pending <= (pending & ~clr) | edge`.
  - `clr = value_in[NSRC-1:0]` when `wen && address==ADDR_PEND`; otherwise `clr` is 0.
  - When an edge and a clear hit the same bit in the same cycle, the set wins.
  - Edges are latched regardless of the mask.
- `mask` is written with `value_in[NSRC-1:0]` on `wen && address==ADDR_MASK`. Writes to ADDR_ID are ignored.
- `active = pending & mask`. `any = |active`.
- ID encoder: `idx` is the lowest-numbered set bit of `active`. `id_byte = {any, 4'b0, idx[2:0]}`. With no active source, `id_byte` is 8'h00.
- Read path. On each clk edge where `address` matches, `port_out` loads the selected value. `ren` does not gate the load. When no address matches, `port_out` holds its value.
  - ADDR_MASK: mask, zero-extended.
  - ADDR_PEND: pending, zero-extended.
  - ADDR_ID: `id_byte`.
- FSM, state register `st`:
  - IDLE: `interrupt=0`. Go to ASSERT when `any`.
  - ASSERT: `interrupt=1`.
    - If `interrupt_ack`, go to SERVICE. Ack takes priority over `any` dropping in the same cycle.
    - Otherwise, if `!any` (masked or cleared before ack), return to IDLE with no interrupt delivered.
  - SERVICE: `interrupt=0`. Stay in SERVICE until `!any`, then go to IDLE. A new edge during SERVICE keeps `any` high, so the FSM stays in SERVICE; the interrupt is re-raised via IDLE only after firmware clears all active bits.
  - `interrupt_ack` outside ASSERT is ignored.
- `interrupt` is a registered output decoded from `st`: it is 1 only in ASSERT.

## Timing
- Reset values: `st`=IDLE, `interrupt`=0, `port_out`=8'h00, `mask`=0, `pending`=0, `prev`=0. Reset during ASSERT drops `interrupt` at that same edge. Reset overrides every write, edge and ack.
- Edge latency:
  - `irq_in[i]` goes high before edge k → `pending[i]`=1 after edge k.
  - If `mask[i]`=1, `st`=ASSERT and `interrupt`=1 after edge k+1.
- Ack latency: `interrupt_ack` high at edge m → `interrupt`=0 after edge m.
- Register writes take effect after the edge that samples `wen`. A mask write enabling an already-pending bit raises `interrupt` one edge later.
- Read latency: `port_out` is valid one cycle after `address` is presented. This holds for the PicoBlaze two-cycle I/O.
- `irq_in` pulses of one cycle are captured. A level held high produces only one edge. A new edge on an already-pending bit is merged into that bit.

## Test plan
- Reset, then read all three addresses → 8'h00 each. `interrupt`=0.
- Write mask 8'h05. Pulse `irq_in[2]` for 1 cycle → pending=8'h04 and `interrupt`=1 two edges after the pulse. Read ADDR_ID → 8'h82.
- With `irq_in[0]` and `irq_in[2]` pending and mask 8'h05, pulse `interrupt_ack` → `interrupt`=0 next edge. Write ADDR_PEND 8'h01 → ADDR_ID reads 8'h82. Write 8'h04 → FSM returns to IDLE and `interrupt` stays 0.
- Set `pending[1]` with mask 8'h00 → no interrupt. Write mask 8'h02 → `interrupt`=1 after two edges. Write mask 8'h00 before any ack → `interrupt` falls and FSM returns to IDLE.
- Edge on `irq_in[3]` in the same cycle as a write of 8'h08 to ADDR_PEND → `pending[3]` remains 1.
- Assert `rst` while `interrupt`=1 and pending=8'h0F → all outputs and registers are 0 after that edge. `irq_in` held high through reset yields one new edge after release.

Source files
------------

// File: rtl/int_ctrl.sv
// Interrupt controller: latches rising edges from up to 8 sources, masks them,
// raises the CPU interrupt line and exposes mask/pending/source-ID registers on the port bus.
module int_ctrl #(
  parameter int          NSRC      = 4,
  parameter logic [7:0]  ADDR_MASK = 8'h00,
  parameter logic [7:0]  ADDR_PEND = 8'h01,
  parameter logic [7:0]  ADDR_ID   = 8'h02
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      address,
  input  logic [7:0]      value_in,
  input  logic            wen,
  input  logic            ren,
  input  logic [NSRC-1:0] irq_in,
  output logic [7:0]      port_out,
  output logic            interrupt,
  input  logic            interrupt_ack
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [NSRC-1:0] prev;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] edges;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] active;
  logic            any;
  logic            found;
  logic [2:0]      idx;
  logic [7:0]      id_byte;
  logic [7:0]      mask_ext;
  logic [7:0]      pend_ext;
  logic [1:0]      st;
  logic [1:0]      st_next;
  logic            unused_ok;

  // Reads are not qualified by ren, and value_in bits above NSRC are don't-care.
  assign unused_ok = ^{ren, value_in};

  assign edges  = irq_in & ~prev;
  assign clr    = (wen && address == ADDR_PEND) ? value_in[NSRC-1:0] : '0;
  assign active = pending & mask;
  assign any    = |active;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (active[i] && !found) begin
        idx   = 3'(i);
        found = 1'b1;
      end
    end
  end

  assign id_byte = {any, 4'b0000, idx};

  always_comb begin
    mask_ext = '0;
    pend_ext = '0;
    mask_ext[NSRC-1:0] = mask;
    pend_ext[NSRC-1:0] = pending;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev    <= '0;
      pending <= '0;
      mask    <= '0;
    end else begin
      prev    <= irq_in;
      pending <= (pending & ~clr) | edges;
      if (wen && address == ADDR_MASK)
        mask <= value_in[NSRC-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      port_out <= '0;
    else if (address == ADDR_MASK)
      port_out <= mask_ext;
    else if (address == ADDR_PEND)
      port_out <= pend_ext;
    else if (address == ADDR_ID)
      port_out <= id_byte;
  end

  always_comb begin
    st_next = st;
    case (st)
      ST_IDLE:    if (any) st_next = ST_ASSERT;
      ST_ASSERT:  if (interrupt_ack) st_next = ST_SERVICE;
                  else if (!any) st_next = ST_IDLE;
      ST_SERVICE: if (!any) st_next = ST_IDLE;
      default:    st_next = ST_IDLE;
    endcase
  end

  // interrupt is registered from the next state so it tracks st without a cycle of lag.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_IDLE;
      interrupt <= 1'b0;
    end else begin
      st        <= st_next;
      interrupt <= (st_next == ST_ASSERT);
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Testbench for int_ctrl: directed scenarios followed by randomized traffic,
// both checked every cycle against a behavioural model of the controller.
module tb_int_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] address;
  logic [7:0] value_in;
  logic       wen;
  logic       ren;
  logic [3:0] irq_in;
  logic [7:0] port_out;
  logic       interrupt;
  logic       interrupt_ack;

  int passed = 0;
  int total  = 0;

  // Behavioural model state
  logic [3:0] m_prev, m_pend, m_mask;
  logic       m_raised, m_svc;
  logic [7:0] m_port;

  int_ctrl #(
    .NSRC(4),
    .ADDR_MASK(8'h00),
    .ADDR_PEND(8'h01),
    .ADDR_ID(8'h02)
  ) dut (
    .clk(clk),
    .rst(rst),
    .address(address),
    .value_in(value_in),
    .wen(wen),
    .ren(ren),
    .irq_in(irq_in),
    .port_out(port_out),
    .interrupt(interrupt),
    .interrupt_ack(interrupt_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_id(input logic [3:0] act);
    for (int i = 0; i < 4; i++)
      if (act[i]) return 8'h80 | 8'(i);
    return 8'h00;
  endfunction

  // Applies one clock edge worth of the controller's rules to the model.
  task automatic model_edge();
    logic [3:0] act;
    logic       any;
    act = m_pend & m_mask;
    any = (act != 4'h0);
    if (rst) begin
      m_prev = 0; m_pend = 0; m_mask = 0; m_raised = 0; m_svc = 0; m_port = 0;
      return;
    end
    case (address)
      8'h00:   m_port = {4'h0, m_mask};
      8'h01:   m_port = {4'h0, m_pend};
      8'h02:   m_port = exp_id(act);
      default: ;
    endcase
    if (m_raised) begin
      if (interrupt_ack) begin m_raised = 0; m_svc = 1; end
      else if (!any) m_raised = 0;
    end else if (m_svc) begin
      if (!any) m_svc = 0;
    end else begin
      m_raised = any;
    end
    if (wen && address == 8'h01) m_pend = m_pend & ~value_in[3:0];
    m_pend = m_pend | (irq_in & ~m_prev);
    if (wen && address == 8'h00) m_mask = value_in[3:0];
    m_prev = irq_in;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("interrupt", {7'b0, interrupt}, {7'b0, m_raised});
    chk("port_out", port_out, m_port);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] v);
    address = a; value_in = v; wen = 1'b1;
    tick();
    wen = 1'b0;
  endtask

  initial begin
    rst = 1'b1; address = 8'h00; value_in = 8'h00; wen = 1'b0; ren = 1'b0;
    irq_in = 4'h0; interrupt_ack = 1'b0;
    m_prev = 0; m_pend = 0; m_mask = 0; m_raised = 0; m_svc = 0; m_port = 0;
    tick(); tick();
    rst = 1'b0;

    // Reset state visible at every register address
    for (int a = 0; a < 3; a++) begin
      address = 8'(a); ren = 1'b1;
      tick();
      chk("reset_read", port_out, 8'h00);
    end
    ren = 1'b0;
    chk("reset_int", {7'b0, interrupt}, 8'h00);

    // Single-cycle pulse on source 2 with mask 05
    wr(8'h00, 8'h05);
    address = 8'h02;
    irq_in = 4'h4; tick();
    irq_in = 4'h0; tick();
    chk("pulse_int", {7'b0, interrupt}, 8'h01);
    chk("pulse_id", port_out, 8'h82);

    // Source 0 also pending, then ack and clear one bit at a time
    irq_in = 4'h1; tick();
    irq_in = 4'h0; tick();
    interrupt_ack = 1'b1; tick();
    interrupt_ack = 1'b0;
    chk("ack_int", {7'b0, interrupt}, 8'h00);
    wr(8'h01, 8'h01);
    address = 8'h02; tick();
    chk("clr0_id", port_out, 8'h82);
    wr(8'h01, 8'h04);
    tick(); tick();
    chk("clr_all_int", {7'b0, interrupt}, 8'h00);

    // Masked pending bit, enable via mask, then withdraw before ack
    wr(8'h00, 8'h00);
    irq_in = 4'h2; tick();
    irq_in = 4'h0; tick(); tick();
    chk("masked_int", {7'b0, interrupt}, 8'h00);
    wr(8'h00, 8'h02);
    tick();
    chk("unmask_int", {7'b0, interrupt}, 8'h01);
    wr(8'h00, 8'h00);
    tick();
    chk("withdraw_int", {7'b0, interrupt}, 8'h00);
    wr(8'h01, 8'hFF);

    // Edge and clear on the same bit in the same cycle: set wins
    irq_in = 4'h8; wr(8'h01, 8'h08);
    irq_in = 4'h0; address = 8'h01; tick();
    chk("set_wins", port_out, 8'h08);
    wr(8'h01, 8'h0F);

    // Reset while asserted, with sources held high across reset
    wr(8'h00, 8'h0F);
    irq_in = 4'hF; tick(); tick();
    chk("pre_rst_int", {7'b0, interrupt}, 8'h01);
    rst = 1'b1; tick();
    chk("rst_int", {7'b0, interrupt}, 8'h00);
    chk("rst_port", port_out, 8'h00);
    rst = 1'b0; address = 8'h01; tick(); tick();
    chk("post_rst_pend", port_out, 8'h0F);
    tick();
    chk("level_once_pend", port_out, 8'h0F);
    irq_in = 4'h0;

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst           = ($urandom_range(0, 59) == 0);
      address       = 8'($urandom_range(0, 3));
      value_in      = 8'($urandom);
      wen           = ($urandom_range(0, 3) == 0);
      ren           = 1'($urandom);
      interrupt_ack = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) == 0) irq_in = 4'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
